// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector
//   Consumer side of a toggle-cover pulse vector. Each cover point's first hit
//   is latched into a sticky bitmap and queued as pending. Pending points are
//   streamed out one global index per valid/ready handshake, lowest index
//   first. A running count of distinct covered points is kept alongside.
//   clear starts a new coverage epoch; reset abandons everything.

module cover_toggle_collector #(
  parameter int unsigned     WIDTH       = 36,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 38253,
  parameter int unsigned     IDX_W       = 64,
  parameter int unsigned     CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   valid,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_index,
  output logic [CNT_W-1:0]   covered_count,
  output logic               all_covered
);

  // Width of a local bit position inside this instance.
  localparam int unsigned K_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // This instance's slice of the global index space must fit inside the total.
  generate
    if (COVER_INDEX + 64'(WIDTH) > COVER_TOTAL) begin : g_range_check
      $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] covered_reg;
  logic [WIDTH-1:0] pending_reg;
  logic [CNT_W-1:0] count_reg;
  logic             out_valid_reg;
  logic [IDX_W-1:0] out_index_reg;

  // ---------------------------------------------------------------------------
  // Combinational next-state terms
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] new_hits;       // first-time hits this cycle
  logic [WIDTH-1:0] covered_next;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] pick_mask;      // one-hot of the pending bit being dispatched
  logic [K_W-1:0]   pick_idx;       // lowest set bit of registered pending
  logic             pick_any;
  logic             load;           // output register may take a new value
  logic [CNT_W-1:0] hit_count;      // popcount of new_hits
  logic [CNT_W-1:0] count_next;
  logic [IDX_W-1:0] out_index_next;

  assign new_hits = valid & ~covered_reg;
  assign load     = !out_valid_reg || out_ready;
  assign pick_any = |pending_reg;

  // Lowest-index-first selection among registered pending bits.
  always_comb begin
    pick_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        pick_idx = K_W'(i);
      end
    end
  end

  // Per-bit sticky capture and pending bookkeeping. A freshly captured bit
  // can never collide with the pick, because the pick is taken from the
  // registered pending vector where that bit is still clear.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign pick_mask[gi]    = load && pick_any && (pick_idx == K_W'(gi));
      assign covered_next[gi] = covered_reg[gi] | new_hits[gi];
      assign pending_next[gi] = (pending_reg[gi] & ~pick_mask[gi]) | new_hits[gi];
    end
  endgenerate

  // Count of first-time hits this cycle; several may land together.
  always_comb begin
    hit_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit_count = hit_count + CNT_W'(new_hits[i]);
    end
  end

  // Running count stays <= WIDTH since each point contributes at most once.
  assign count_next     = count_reg + hit_count;
  assign out_index_next = IDX_W'(COVER_INDEX) + IDX_W'(pick_idx);

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Coverage bitmaps and count: reset and clear wipe, otherwise capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      covered_reg <= '0;
      pending_reg <= '0;
      count_reg   <= '0;
    end else if (clear) begin
      covered_reg <= '0;
      pending_reg <= '0;
      count_reg   <= '0;
    end else begin
      covered_reg <= covered_next;
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  // Output register: loads the next pending index when empty or accepted,
  // holds steady under back-pressure; clear drops an unaccepted index.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_index_reg <= '0;
    end else if (clear) begin
      out_valid_reg <= 1'b0;
      out_index_reg <= '0;
    end else if (load) begin
      if (pick_any) begin
        out_valid_reg <= 1'b1;
        out_index_reg <= out_index_next;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_index     = out_index_reg;
  assign covered_count = count_reg;
  assign all_covered   = (count_reg == CNT_W'(WIDTH));

endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector
//   Scenario tasks for cover_toggle_collector plus a randomized run checked
//   against a set-based behavioural model of the collector.

module tb_cover_toggle_collector;

  localparam int              W  = 36;
  localparam longint unsigned CI = 1000;
  localparam int              IW = 64;
  localparam int              CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  valid;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [CW-1:0] covered_count;
  logic          all_covered;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: set of covered points, set of points awaiting report,
  // and the index currently offered downstream.
  logic [W-1:0]    m_cov;
  logic [W-1:0]    m_pend;
  logic            m_ov;
  longint unsigned m_idx;

  // Indices actually accepted by downstream (valid && ready at an edge).
  longint unsigned hs_q[$];

  cover_toggle_collector #(
    .WIDTH       (W),
    .COVER_INDEX (CI),
    .COVER_TOTAL (38253),
    .IDX_W       (IW),
    .CNT_W       (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .valid         (valid),
    .clear         (clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance the model by one clock using the rules for capture and dispatch.
  task automatic model_edge(input logic [W-1:0] v, input logic c, input logic r,
                            input logic rst);
    logic [W-1:0] fresh;
    int lowest;
    if (rst) begin
      m_cov = '0; m_pend = '0; m_ov = 1'b0; m_idx = 0;
    end else if (c) begin
      m_cov = '0; m_pend = '0; m_ov = 1'b0;
    end else begin
      fresh = v & ~m_cov;
      if (!m_ov || r) begin
        lowest = -1;
        for (int i = 0; i < W; i++)
          if (m_pend[i] && lowest < 0) lowest = i;
        if (lowest >= 0) begin
          m_pend[lowest] = 1'b0;
          m_ov  = 1'b1;
          m_idx = CI + longint'(lowest);
        end else begin
          m_ov = 1'b0;
        end
      end
      m_pend = m_pend | fresh;
      m_cov  = m_cov | fresh;
    end
  endtask

  // Drive one cycle of inputs, log any handshake, then sample #1 after the edge.
  task automatic step(input logic [W-1:0] v, input logic c, input logic r,
                      input logic rst);
    valid = v; clear = c; out_ready = r; reset = rst;
    if (!rst && out_valid === 1'b1 && r) hs_q.push_back(out_index);
    model_edge(v, c, r, rst);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(rand_vec(), 1'b0, 1'b1, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_index !== '0) begin n_fail++; $display("FAIL reset_out_index got=%0d exp=0", out_index); end
    n_checks++; if (covered_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", covered_count); end
    n_checks++; if (all_covered !== 1'b0) begin n_fail++; $display("FAIL reset_all_covered got=%b exp=0", all_covered); end
    step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ignores_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_hit();
    step(W'(1), 1'b0, 1'b1, 1'b0);
    n_checks++; if (covered_count !== CW'(1)) begin n_fail++; $display("FAIL single_count_t1 got=%0d exp=1", covered_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_t1 got=%b exp=0", out_valid); end
    step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_t2 got=%b exp=1", out_valid); end
    n_checks++; if (out_index !== IW'(CI)) begin n_fail++; $display("FAIL single_index got=%0d exp=%0d", out_index, CI); end
    step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_once got=%b exp=0", out_valid); end
    step('0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_multi_hit();
    longint unsigned exp_idx[3] = '{CI, CI + 3, CI + 35};
    logic [W-1:0] m;
    m = '0; m[0] = 1'b1; m[3] = 1'b1; m[35] = 1'b1;
    step(m, 1'b0, 1'b1, 1'b0);
    n_checks++; if (covered_count !== CW'(3)) begin n_fail++; $display("FAIL multi_count got=%0d exp=3", covered_count); end
    for (int j = 0; j < 3; j++) begin
      step('0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_index !== IW'(exp_idx[j])) begin
        n_fail++; $display("FAIL multi_seq%0d got v=%b idx=%0d exp v=1 idx=%0d", j, out_valid, out_index, exp_idx[j]);
      end
    end
    step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL multi_drained got=%b exp=0", out_valid); end
    step('0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_rehit();
    hs_q.delete();
    for (int i = 0; i < 10; i++) step(W'(1) << 5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (hs_q.size() != 1) begin n_fail++; $display("FAIL rehit_reports got=%0d exp=1", hs_q.size()); end
    else begin
      n_checks++; if (hs_q[0] != CI + 5) begin n_fail++; $display("FAIL rehit_index got=%0d exp=%0d", hs_q[0], CI + 5); end
    end
    n_checks++; if (covered_count !== CW'(1)) begin n_fail++; $display("FAIL rehit_count got=%0d exp=1", covered_count); end
    step('0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    longint unsigned exp_idx[4] = '{CI + 2, CI + 7, CI + 9, CI + 30};
    logic [W-1:0] m;
    int held_bad;
    m = '0; m[2] = 1'b1; m[7] = 1'b1; m[9] = 1'b1; m[30] = 1'b1;
    step(m, 1'b0, 1'b0, 1'b0);
    held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step('0, 1'b0, 1'b0, 1'b0);
      if (out_valid !== 1'b1 || out_index !== IW'(CI + 2)) held_bad++;
    end
    n_checks++; if (held_bad != 0) begin n_fail++; $display("FAIL bp_hold got=%0d bad cycles exp=0 (last v=%b idx=%0d)", held_bad, out_valid, out_index); end
    hs_q.delete();
    for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (hs_q.size() != 4) begin n_fail++; $display("FAIL bp_release_count got=%0d exp=4", hs_q.size()); end
    else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++; if (hs_q[j] != exp_idx[j]) begin n_fail++; $display("FAIL bp_order%0d got=%0d exp=%0d", j, hs_q[j], exp_idx[j]); end
      end
    end
    step('0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_all_and_clear();
    int bad;
    step('1, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (covered_count !== CW'(W)) begin n_fail++; $display("FAIL all_count got=%0d exp=%0d", covered_count, W); end
    n_checks++; if (all_covered !== 1'b1) begin n_fail++; $display("FAIL all_covered got=%b exp=1", all_covered); end
    hs_q.delete();
    for (int i = 0; i < W + 2; i++) step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (hs_q.size() != W) begin n_fail++; $display("FAIL all_reports got=%0d exp=%0d", hs_q.size(), W); end
    else begin
      bad = 0;
      for (int j = 0; j < W; j++) if (hs_q[j] != CI + longint'(j)) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL all_order got=%0d misplaced exp=0", bad); end
    end
    step('0, 1'b1, 1'b1, 1'b0);
    step(W'(3), 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_pre_valid got=%b exp=1", out_valid); end
    step('1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (covered_count !== '0) begin n_fail++; $display("FAIL clear_count got=%0d exp=0", covered_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (all_covered !== 1'b0) begin n_fail++; $display("FAIL clear_all_covered got=%b exp=0", all_covered); end
    step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (covered_count !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_discard got count=%0d v=%b exp count=0 v=0", covered_count, out_valid); end
    step(W'(1), 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_index !== IW'(CI)) begin n_fail++; $display("FAIL clear_rehit got v=%b idx=%0d exp v=1 idx=%0d", out_valid, out_index, CI); end
    n_checks++; if (covered_count !== CW'(1)) begin n_fail++; $display("FAIL clear_rehit_count got=%0d exp=1", covered_count); end
    step('0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midstream();
    int bad;
    step('1, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    step('0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || out_index !== '0 || covered_count !== '0 || all_covered !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got v=%b idx=%0d cnt=%0d all=%b exp all zero", out_valid, out_index, covered_count, all_covered);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b0, 1'b1, 1'b0);
      if (out_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_quiet got=%0d emitting cycles exp=0", bad); end
    step(W'(1) << 4, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_index !== IW'(CI + 4)) begin n_fail++; $display("FAIL mid_new_hit got v=%b idx=%0d exp v=1 idx=%0d", out_valid, out_index, CI + 4); end
    step('0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    logic c, r;
    for (int n = 0; n < 500; n++) begin
      v = ($urandom_range(0, 2) == 0) ? (rand_vec() & rand_vec() & rand_vec()) : '0;
      c = ($urandom_range(0, 79) == 0);
      r = ($urandom_range(0, 3) != 0);
      step(v, c, r, 1'b0);
      n_checks++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", n, out_valid, m_ov); end
      if (m_ov) begin
        n_checks++; if (out_index !== IW'(m_idx)) begin n_fail++; $display("FAIL rand_index cyc=%0d got=%0d exp=%0d", n, out_index, m_idx); end
      end
      n_checks++; if (covered_count !== CW'($countones(m_cov))) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", n, covered_count, $countones(m_cov)); end
      n_checks++; if (all_covered !== (m_cov == '1)) begin n_fail++; $display("FAIL rand_all cyc=%0d got=%b exp=%b", n, all_covered, (m_cov == '1)); end
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; out_ready = 1'b0; valid = '0;
    m_cov = '0; m_pend = '0; m_ov = 1'b0; m_idx = 0;
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_rehit();
    test_backpressure();
    test_all_and_clear();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
